// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer/UART-side signal bundle for the transmit FIFO
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
) ();
    logic                  wr;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  tx_err;
    logic                  busy_tx;
    logic                  transmit;
    logic [7:0]            data_tx;

    modport master (
        output wr, wr_data, busy_tx,
        input  full, empty, count, overflow, tx_err, transmit, data_tx
    );

    modport slave (
        input  wr, wr_data, busy_tx,
        output full, empty, count, overflow, tx_err, transmit, data_tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - circular byte FIFO that launches bytes into uart_autobaud paced on busy_tx
module uart_tx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           nRst,
    uart_tx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, ACK, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  tx_err_q, tx_err_d;
    logic                  transmit_q, transmit_d;
    logic [7:0]            data_tx_q, data_tx_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  push;
    logic                  pop;

    // Both decisions use the registered flags so a pop never frees room for a same-edge write.
    assign push = bus.wr && !full_q;
    assign pop  = (state_q == IDLE) && !empty_q && !bus.busy_tx;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_tx_d  = data_tx_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            data_tx_d = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d     = count_d[DEPTH_LOG2];
        empty_d    = (count_d == '0);
        overflow_d = bus.wr && full_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = LAUNCH;
            LAUNCH:  state_d = ACK;
            ACK: begin
                if (bus.busy_tx) begin
                    state_d = DRAIN;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end
            end
            DRAIN:   if (!bus.busy_tx) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        transmit_d = pop;
        tx_err_d   = (state_q == ACK) && !bus.busy_tx && (tmo_q == TMO_LAST);
        tmo_d      = tmo_q;
        if (state_q == LAUNCH) begin
            tmo_d = '0;
        end else if ((state_q == ACK) && !bus.busy_tx && (tmo_q != TMO_LAST)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_err_q   <= 1'b0;
            transmit_q <= 1'b0;
            data_tx_q  <= 8'h00;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_err_q   <= tx_err_d;
            transmit_q <= transmit_d;
            data_tx_q  <= data_tx_d;
            tmo_q      <= tmo_d;
        end
    end

    // Storage is deliberately left unreset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.tx_err   = tx_err_q;
    assign bus.transmit = transmit_q;
    assign bus.data_tx  = data_tx_q;
endmodule
